// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle RISC-V control path: FSM states,
// opcodes, ALU operation codes and the immediate-format decode helper.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } statetype_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        logic [1:0] imm;
        imm = IMM_I;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU operation decode: maps the FSM's ALUOp class plus instruction fields
// to the 3-bit ALUControl code consumed by the ALU.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FN: begin
                case (funct3_i)
                    // Only R-type (op[5]=1) can request sub; addi ignores funct7b5.
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control FSM driving ALU control, mux selects and enables.
// Optional macro CTRL_BNE_EN adds bne (funct3=001) resolution in the BEQ state.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter statetype_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [2:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       illegal_op
);

    statetype_t state_q, state_d;

    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       taken;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic       mem_write_raw;
    logic       illegal_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = S_FETCH;
        alu_op        = ALUOP_ADD;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        AdrSrc        = 1'b0;
        ir_write_raw  = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d      = S_DECODE;
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                pc_update    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                state_d = S_MEMWB;
                AdrSrc  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                state_d = S_ALUWB;
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FN;
            end
            S_EXECUTEI: begin
                state_d = S_ALUWB;
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FN;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                state_d   = S_ALUWB;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

`ifdef CTRL_BNE_EN
    always_comb begin
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            default: taken = 1'b0;
        endcase
    end
`else
    assign taken = zero;
`endif

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (ALUControl)
    );

    assign ImmSrc = imm_src(op);

    // Enables are gated by reset directly so they drop the instant reset rises.
    assign IRWrite    = ir_write_raw & ~reset;
    assign PCWrite    = (pc_update | (branch & taken)) & ~reset;
    assign RegWrite   = reg_write_raw & ~reset;
    assign MemWrite   = mem_write_raw & ~reset;
    assign illegal_op = illegal_raw & ~reset;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle RISC-V control unit; sits directly upstream of the 32-bit ALU.
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback states.
- Drives the ALU's 3-bit ALUControl code and all datapath mux selects and write enables.
- Consumes the ALU zero flag to resolve branches.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset and after every completed instruction.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  instruction opcode, instr[6:0], from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag; 1 when a-b == 0.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 data.
- ALUSrcB  out  2  00 rs2 data, 01 immediate, 10 constant 4.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALU result.
- ImmSrc  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type.
- AdrSrc  out  1  0 PC, 1 Result.
- IRWrite  out  1  instruction register load.
- PCWrite  out  1  PC load = PCUpdate | (Branch & taken).
- RegWrite  out  1  register file write.
- MemWrite  out  1  data memory write.
- illegal_op  out  1  one-cycle pulse in Decode for an unsupported opcode.

Behaviour:
- Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- The state register uses asynchronous active-high reset to FETCH.
- While reset is high, IRWrite, PCWrite, RegWrite, MemWrite and illegal_op are forced to 0. All other outputs take their FETCH values.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: lw(0000011) or sw(0100011) -> MEMADR; R(0110011) -> EXECUTER; I-ALU(0010011) -> EXECUTEI; jal(1101111) -> JAL; beq(1100011) -> BEQ; any other opcode -> FETCH with illegal_op=1.
  - MEMADR -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD -> MEMWB.
  - EXECUTER, EXECUTEI, JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- Per-state outputs (unlisted enables 0, unlisted selects 00):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcB=10, ResultSrc=10, ALUOp=00, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: RegWrite=1.
  - BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- ALU decode:
  - ALUOp 00 -> 000 (add); ALUOp 01 -> 001 (sub).
  - ALUOp 10, by funct3:
    - 000: 001 (sub) only when op[5] & funct7b5, else 000.
    - 010: 100 (slt).
    - 110: 011 (or).
    - 111: 010 (and).
    - Any other funct3: 000; never X.
  - ALUOp 11 is unused and maps to 000.
- ImmSrc is decoded combinationally from op: lw/I-ALU 00, sw 01, beq 10, jal 11, else 00.
- Branch taken = zero, sampled combinationally in BEQ.
- PCWrite is combinational within the BEQ cycle.
- Latency (cycles): lw 5, sw 4, R/I 4, jal 4, beq 3.
- Reset mid-instruction aborts immediately. No write enable may glitch high on reset release. The first cycle after release is FETCH.

Optional Feature:
- Macro CTRL_BNE_EN.
- Defined: in BEQ with funct3=001 (bne), taken = ~zero; funct3=000 keeps taken = zero; other funct3 values are never taken.
- Undefined: BEQ ignores funct3 and taken = zero always.

Decomposition:
- Shared package mc_pkg holds:
  - the statetype_t enum;
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ);
  - ALUControl localparams (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=100), used by the ALU and this block alike.
- One natural combinational sub-module: alu_decoder (ALUOp, funct3, op[5], funct7b5 -> ALUControl).

Test Plan:
- Reset asserted mid-MEMWRITE, then released: MemWrite drops to 0 asynchronously; next cycle is FETCH with IRWrite=1, ALUSrcB=10.
- add (op=0110011, funct3=000, funct7b5=0): 4 cycles; EXECUTER ALUControl=000; ALUWB RegWrite=1.
- sub (funct7b5=1): EXECUTER ALUControl=001.
- addi with funct7b5=1: EXECUTEI ALUControl=000 (op[5]=0 blocks the sub decode).
- lw: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; MEMREAD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1.
- beq with zero=1: BEQ PCWrite=1, ALUControl=001. With zero=0: PCWrite=0; then FETCH.
- op=1111111: DECODE illegal_op=1 for one cycle, then FETCH; no write enable asserted.
- With CTRL_BNE_EN defined, bne (funct3=001) with zero=0: PCWrite=1. With zero=1: PCWrite=0.
